vga_fb_ctrl: RTL and testbench
==============================

VGA_FB_CTRL -- requirements
Module: vga_fb_ctrl

Interface
REQ-001 SHALL have parameter H_ACT, default 540, meaning active pixels per displayed line.
REQ-002 SHALL have parameter V_ACT, default 360, meaning active displayed lines per frame; PIX = H_ACT*V_ACT = 194400.
REQ-003 SHALL have parameter AW, default 18, meaning BRAM address width; AW must hold PIX-1.
REQ-004 SHALL have port clk_65  in  1  pixel clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have port vga_vs_i  in  1  VSYNC from the VGA timing block; active low.
REQ-007 SHALL have port bram_en_i  in  1  display read enable from the VGA timing block; one pixel per cycle when high.
REQ-008 SHALL have port wr_valid_i  in  1  writer pixel valid.
REQ-009 SHALL have port wr_data_i  in  8  writer pixel data.
REQ-010 SHALL have port wr_ready_o  out  1  writer pixel accepted when wr_valid_i and wr_ready_o are both high.
REQ-011 SHALL have port wr_en_o / wr_bank_o / wr_addr_o / wr_data_o  out  1/1/AW/8  BRAM write port.
REQ-012 SHALL have port rd_bank_o / rd_addr_o  out  1/AW  BRAM display read port.
REQ-013 SHALL have port frame_swap_o  out  1  one-cycle pulse on a bank swap.
REQ-014 SHALL have port underrun_cnt_o  out  16  count of frames displayed without a fresh swap.

Function
REQ-015 SHALL register vga_vs_i once; vs_start pulses for one cycle when the registered value is 1 and the current vga_vs_i is 0.
REQ-016 SHALL use ping-pong banks: disp_bank drives rd_bank_o; wr_bank = ~disp_bank always.
REQ-017 SHALL set rd_addr to 0 on vs_start, otherwise increment it when bram_en_i=1; it saturates at PIX-1, with no wrap.
REQ-018 SHALL implement FSM states IDLE, FILL and WAIT_SWAP.
REQ-019 IDLE: wr_ready_o=0; on vs_start the FSM goes to FILL with wr_addr=0 and performs no swap.
REQ-020 FILL: wr_ready_o=1; on each accepted pixel, wr_addr increments; if the accepted pixel has wr_addr==PIX-1, the FSM goes to WAIT_SWAP.
REQ-021 WAIT_SWAP: wr_ready_o=0; on vs_start the block toggles disp_bank, clears wr_addr to 0, pulses frame_swap_o, and goes to FILL.
REQ-022 SHALL register the write port with 1-cycle latency: the cycle after an accept, wr_en_o=1, wr_addr_o equals the accepted address, wr_data_o equals the accepted data, and wr_bank_o equals the bank at accept.
REQ-023 If the last pixel is accepted in the same cycle as vs_start, the FSM SHALL enter WAIT_SWAP and swap only on the next vs_start; frames are never torn.
REQ-024 vs_start while in FILL SHALL leave the bank and wr_addr unchanged; the writer continues.
REQ-025 wr_valid_i while wr_ready_o=0 SHALL be ignored; wr_data_i is not captured.

Reset
REQ-026 While rst=1, the block SHALL hold: state IDLE, disp_bank=0, wr_addr=0, rd_addr=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, frame_swap_o=0, underrun_cnt_o=0, and the vsync register=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately; after release, the block waits for the next vs_start.

Configuration
REQ-028 With macro VGA_FB_UNDERRUN_CNT_EN defined, the counter SHALL increment on each vs_start while in FILL and saturate at 16'hFFFF.
REQ-029 Without VGA_FB_UNDERRUN_CNT_EN, underrun_cnt_o SHALL be constant 0 and no counter logic is built.

Verification
REQ-030 Reset then first vga_vs_i falling edge -> the FSM enters FILL, wr_ready_o=1, frame_swap_o stays 0, rd_bank_o=0.
REQ-031 Write 194400 pixels, then a vs falling edge -> wr_ready_o drops after pixel 194399, one frame_swap_o pulse occurs, rd_bank_o=1, and the next write uses wr_bank_o=0 at wr_addr_o=0.
REQ-032 Hold bram_en_i high for 200000 cycles after vs_start -> rd_addr_o reaches 194399 and holds there.
REQ-033 Accept the last pixel in the same cycle as vs_start -> no swap occurs; the swap happens at the following vs_start.
REQ-034 Three vs_starts with the writer stalled in FILL, macro defined -> underrun_cnt_o=3; with the macro undefined -> underrun_cnt_o=0.
REQ-035 Assert rst at wr_addr=1000 -> all outputs reach their reset values asynchronously, and wr_ready_o=0 until the next vs_start.

Source files
------------

// File: rtl/vga_fb_ctrl.sv
// vga_fb_ctrl: ping-pong frame buffer controller between a pixel writer and
// the VGA display read path. The writer fills the back bank, and the banks
// swap only on a VSYNC falling edge after a complete frame, so a displayed
// frame is never torn.
// Optional feature: define VGA_FB_UNDERRUN_CNT_EN to build the underrun
// counter (frames shown while the writer was still filling).
//
// state     | meaning
// IDLE      | after reset, waiting for the first VSYNC falling edge
// FILL      | accepting writer pixels into the back bank
// WAIT_SWAP | back bank complete, waiting for VSYNC to swap banks
module vga_fb_ctrl #(
   parameter int H_ACT = 540,
   parameter int V_ACT = 360,
   parameter int AW    = 18
) (
   input  logic          clk_65,
   input  logic          rst,
   input  logic          vga_vs_i,
   input  logic          bram_en_i,
   input  logic          wr_valid_i,
   input  logic [7:0]    wr_data_i,
   output logic          wr_ready_o,
   output logic          wr_en_o,
   output logic          wr_bank_o,
   output logic [AW-1:0] wr_addr_o,
   output logic [7:0]    wr_data_o,
   output logic          rd_bank_o,
   output logic [AW-1:0] rd_addr_o,
   output logic          frame_swap_o,
   output logic [15:0]   underrun_cnt_o
);

   localparam int PIX = H_ACT * V_ACT;
   localparam logic [AW-1:0] LAST_ADDR = AW'(PIX - 1);

   typedef enum logic [1:0] {IDLE, FILL, WAIT_SWAP} state_t;

   state_t        state;
   logic          vs_q;
   logic          vs_start;
   logic          accept;
   logic          disp_bank;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;

   assign vs_start  = vs_q & ~vga_vs_i;
   assign accept    = wr_valid_i & wr_ready_o;
   assign rd_bank_o = disp_bank;
   assign rd_addr_o = rd_addr;

   // VSYNC edge detect register; resets high so a low VSYNC at release counts as an edge
   always_ff @(posedge clk_65 or posedge rst) begin
      if (rst) vs_q <= 1'b1;
      else     vs_q <= vga_vs_i;
   end

   // Display read address: restart each frame, saturate at the last pixel
   always_ff @(posedge clk_65 or posedge rst) begin
      if (rst)                                  rd_addr <= '0;
      else if (vs_start)                        rd_addr <= '0;
      else if (bram_en_i && rd_addr != LAST_ADDR) rd_addr <= rd_addr + AW'(1);
   end

   // Fill/swap sequencer with registered ready and swap pulse
   always_ff @(posedge clk_65 or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         disp_bank    <= 1'b0;
         wr_addr      <= '0;
         wr_ready_o   <= 1'b0;
         frame_swap_o <= 1'b0;
      end else begin
         frame_swap_o <= 1'b0;
         case (state)
            IDLE: begin
               if (vs_start) begin
                  state      <= FILL;
                  wr_addr    <= '0;
                  wr_ready_o <= 1'b1;
               end
            end
            FILL: begin
               // a VSYNC here is an underrun: keep filling the same bank
               if (accept) begin
                  if (wr_addr == LAST_ADDR) begin
                     state      <= WAIT_SWAP;
                     wr_ready_o <= 1'b0;
                  end else begin
                     wr_addr <= wr_addr + AW'(1);
                  end
               end
            end
            WAIT_SWAP: begin
               if (vs_start) begin
                  state        <= FILL;
                  disp_bank    <= ~disp_bank;
                  wr_addr      <= '0;
                  wr_ready_o   <= 1'b1;
                  frame_swap_o <= 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               wr_ready_o <= 1'b0;
            end
         endcase
      end
   end

   // BRAM write port, one cycle behind the accept; accepts never coincide with a swap
   always_ff @(posedge clk_65 or posedge rst) begin
      if (rst) begin
         wr_en_o   <= 1'b0;
         wr_bank_o <= 1'b1;
         wr_addr_o <= '0;
         wr_data_o <= '0;
      end else begin
         wr_en_o <= accept;
         if (accept) begin
            wr_bank_o <= ~disp_bank;
            wr_addr_o <= wr_addr;
            wr_data_o <= wr_data_i;
         end
      end
   end

`ifdef VGA_FB_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt;

   // Count frames where VSYNC arrived before the back bank was complete
   always_ff @(posedge clk_65 or posedge rst) begin
      if (rst)
         underrun_cnt <= '0;
      else if (vs_start && state == FILL && underrun_cnt != 16'hFFFF)
         underrun_cnt <= underrun_cnt + 16'd1;
   end

   assign underrun_cnt_o = underrun_cnt;
`else
   assign underrun_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Testbench for vga_fb_ctrl on a reduced 10x6 frame so full frames and
// read saturation fit in a short run. Expected values come from a
// frame-level model that tracks phase, banks, pointers and counts.
module tb_vga_fb_ctrl;

   localparam int H_ACT = 10;
   localparam int V_ACT = 6;
   localparam int AW    = 8;
   localparam int PIX   = H_ACT * V_ACT;

   localparam int P_IDLE = 0;
   localparam int P_FILL = 1;
   localparam int P_WAIT = 2;

   logic          clk_65 = 1'b0;
   logic          rst = 1'b1;
   logic          vga_vs_i = 1'b1;
   logic          bram_en_i = 1'b0;
   logic          wr_valid_i = 1'b0;
   logic [7:0]    wr_data_i = 8'h00;
   logic          wr_ready_o;
   logic          wr_en_o;
   logic          wr_bank_o;
   logic [AW-1:0] wr_addr_o;
   logic [7:0]    wr_data_o;
   logic          rd_bank_o;
   logic [AW-1:0] rd_addr_o;
   logic          frame_swap_o;
   logic [15:0]   underrun_cnt_o;

   int checks = 0;
   int failures = 0;

   // reference model state
   int          m_phase;
   logic        m_vs_prev;
   logic        m_bank;
   int          m_waddr;
   int          m_raddr;
   int          m_under;
   logic        e_wr_en;
   logic        e_wbank;
   logic [7:0]  e_waddr;
   logic [7:0]  e_wdata;
   logic        e_swap;

   vga_fb_ctrl #(.H_ACT(H_ACT), .V_ACT(V_ACT), .AW(AW)) dut (
      .clk_65(clk_65), .rst(rst), .vga_vs_i(vga_vs_i), .bram_en_i(bram_en_i),
      .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
      .wr_en_o(wr_en_o), .wr_bank_o(wr_bank_o), .wr_addr_o(wr_addr_o),
      .wr_data_o(wr_data_o), .rd_bank_o(rd_bank_o), .rd_addr_o(rd_addr_o),
      .frame_swap_o(frame_swap_o), .underrun_cnt_o(underrun_cnt_o)
   );

   always #5 clk_65 = ~clk_65;

   logic [44:0] dut_vec;
   assign dut_vec = {wr_ready_o, wr_en_o,
                     wr_en_o ? {wr_bank_o, wr_addr_o, wr_data_o} : 17'h0,
                     rd_bank_o, rd_addr_o, frame_swap_o, underrun_cnt_o};

   function automatic logic [44:0] exp_vec();
      logic [16:0] wp;
      wp = e_wr_en ? {e_wbank, e_waddr, e_wdata} : 17'h0;
      return {(m_phase == P_FILL), e_wr_en, wp, m_bank, 8'(m_raddr), e_swap, 16'(m_under)};
   endfunction

   task automatic reset_model();
      m_phase = P_IDLE; m_vs_prev = 1'b1; m_bank = 1'b0; m_waddr = 0;
      m_raddr = 0; m_under = 0; e_wr_en = 1'b0; e_wbank = 1'b1;
      e_waddr = 8'h00; e_wdata = 8'h00; e_swap = 1'b0;
   endtask

   // Advance one clock: model the frame rules for the inputs now applied,
   // then sample the DUT 1 ns after the rising edge.
   task automatic step();
      bit vs_fall, acc;
      if (rst) begin
         @(posedge clk_65); #1;
         reset_model();
         return;
      end
      vs_fall = (m_vs_prev == 1'b1) && (vga_vs_i == 1'b0);
      acc = (m_phase == P_FILL) && wr_valid_i;
      e_wr_en = acc;
      if (acc) begin
         e_waddr = 8'(m_waddr); e_wdata = wr_data_i; e_wbank = ~m_bank;
      end
      e_swap = 1'b0;
      if (vs_fall) m_raddr = 0;
      else if (bram_en_i && m_raddr < PIX - 1) m_raddr++;
`ifdef VGA_FB_UNDERRUN_CNT_EN
      if (vs_fall && m_phase == P_FILL && m_under < 65535) m_under++;
`endif
      if (m_phase == P_IDLE) begin
         if (vs_fall) begin m_phase = P_FILL; m_waddr = 0; end
      end else if (m_phase == P_FILL) begin
         if (acc) begin
            if (m_waddr == PIX - 1) m_phase = P_WAIT;
            else m_waddr++;
         end
      end else if (vs_fall) begin
         m_bank = ~m_bank; m_waddr = 0; e_swap = 1'b1; m_phase = P_FILL;
      end
      m_vs_prev = vga_vs_i;
      @(posedge clk_65); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; vga_vs_i = 1'b1; wr_valid_i = 1'b0; bram_en_i = 1'b0;
      step(); step(); step();
      checks++; if (wr_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", wr_ready_o); end
      checks++; if (wr_en_o !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", wr_en_o); end
      checks++; if (wr_addr_o !== '0) begin failures++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr_o); end
      checks++; if (wr_data_o !== 8'h00) begin failures++; $display("FAIL reset_wr_data got=%h exp=00", wr_data_o); end
      checks++; if (rd_bank_o !== 1'b0) begin failures++; $display("FAIL reset_rd_bank got=%b exp=0", rd_bank_o); end
      checks++; if (rd_addr_o !== '0) begin failures++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr_o); end
      checks++; if (frame_swap_o !== 1'b0) begin failures++; $display("FAIL reset_swap got=%b exp=0", frame_swap_o); end
      checks++; if (underrun_cnt_o !== 16'h0) begin failures++; $display("FAIL reset_underrun got=%0d exp=0", underrun_cnt_o); end
      rst = 1'b0;
      wr_valid_i = 1'b1;
      step(); step();
      checks++; if (wr_ready_o !== 1'b0) begin failures++; $display("FAIL idle_ready got=%b exp=0", wr_ready_o); end
      checks++; if (wr_en_o !== 1'b0) begin failures++; $display("FAIL idle_ignored_valid got=%b exp=0", wr_en_o); end
      wr_valid_i = 1'b0;
   endtask

   task automatic test_first_vs();
      vga_vs_i = 1'b1; step();
      vga_vs_i = 1'b0; step();
      checks++; if (wr_ready_o !== 1'b1) begin failures++; $display("FAIL first_vs_ready got=%b exp=1", wr_ready_o); end
      checks++; if (frame_swap_o !== 1'b0) begin failures++; $display("FAIL first_vs_swap got=%b exp=0", frame_swap_o); end
      checks++; if (rd_bank_o !== 1'b0) begin failures++; $display("FAIL first_vs_bank got=%b exp=0", rd_bank_o); end
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (dut_vec !== exp_vec()) begin failures++; $display("FAIL first_vs_cyc t=%0t got=%h exp=%h", $time, dut_vec, exp_vec()); end
      end
   endtask

   task automatic test_fill_and_swap();
      int n = 0;
      vga_vs_i = 1'b0;
      while (m_phase == P_FILL && n < 1000) begin
         wr_valid_i = ($urandom_range(0, 3) != 0);
         wr_data_i = 8'($urandom_range(0, 255));
         bram_en_i = $urandom_range(0, 1);
         step(); n++;
         checks++; if (dut_vec !== exp_vec()) begin failures++; $display("FAIL fill_cyc t=%0t got=%h exp=%h", $time, dut_vec, exp_vec()); end
      end
      checks++; if (m_phase != P_WAIT) begin failures++; $display("FAIL fill_timeout got=%0d cycles exp=frame complete", n); end
      wr_valid_i = 1'b1;
      step();
      checks++; if (wr_ready_o !== 1'b0 || wr_en_o !== 1'b0) begin failures++; $display("FAIL wait_ready got=%b/%b exp=0/0", wr_ready_o, wr_en_o); end
      wr_valid_i = 1'b0; vga_vs_i = 1'b1; step();
      vga_vs_i = 1'b0; step();
      checks++; if (frame_swap_o !== 1'b1) begin failures++; $display("FAIL swap_pulse got=%b exp=1", frame_swap_o); end
      checks++; if (rd_bank_o !== 1'b1) begin failures++; $display("FAIL swap_bank got=%b exp=1", rd_bank_o); end
      wr_valid_i = 1'b1; wr_data_i = 8'hA5; step();
      checks++; if (frame_swap_o !== 1'b0) begin failures++; $display("FAIL swap_single got=%b exp=0", frame_swap_o); end
      checks++; if ({wr_en_o, wr_bank_o, wr_addr_o, wr_data_o} !== {1'b1, 1'b0, 8'd0, 8'hA5}) begin
         failures++; $display("FAIL post_swap_write got=%b/%b/%0d/%h exp=1/0/0/a5", wr_en_o, wr_bank_o, wr_addr_o, wr_data_o);
      end
      wr_valid_i = 1'b0; bram_en_i = 1'b0;
   endtask

   task automatic test_rd_saturate();
      vga_vs_i = 1'b1; step();
      vga_vs_i = 1'b0; bram_en_i = 1'b1; step();
      for (int i = 0; i < PIX + 20; i++) begin
         step();
         checks++; if (dut_vec !== exp_vec()) begin failures++; $display("FAIL rd_cyc t=%0t got=%h exp=%h", $time, dut_vec, exp_vec()); end
      end
      checks++; if (rd_addr_o !== 8'(PIX - 1)) begin failures++; $display("FAIL rd_saturate got=%0d exp=%0d", rd_addr_o, PIX - 1); end
      bram_en_i = 1'b0;
   endtask

   task automatic test_last_with_vs();
      int n = 0;
      logic bank0;
      vga_vs_i = 1'b0; wr_valid_i = 1'b1;
      while (!(m_phase == P_FILL && m_waddr == PIX - 1) && n < 1000) begin
         wr_data_i = 8'($urandom_range(0, 255));
         step(); n++;
      end
      checks++; if (n >= 1000) begin failures++; $display("FAIL last_setup_timeout got=%0d exp=<1000", n); end
      bank0 = rd_bank_o;
      wr_valid_i = 1'b0; vga_vs_i = 1'b1; step();
      wr_valid_i = 1'b1; vga_vs_i = 1'b0; step();
      checks++; if ({wr_ready_o, frame_swap_o, rd_bank_o} !== {1'b0, 1'b0, bank0}) begin
         failures++; $display("FAIL last_same_vs got=%b%b%b exp=00%b", wr_ready_o, frame_swap_o, rd_bank_o, bank0);
      end
      checks++; if (dut_vec !== exp_vec()) begin failures++; $display("FAIL last_cyc got=%h exp=%h", dut_vec, exp_vec()); end
      wr_valid_i = 1'b0; step(); step();
      checks++; if (frame_swap_o !== 1'b0) begin failures++; $display("FAIL last_no_swap got=%b exp=0", frame_swap_o); end
      vga_vs_i = 1'b1; step();
      vga_vs_i = 1'b0; step();
      checks++; if ({frame_swap_o, rd_bank_o} !== {1'b1, ~bank0}) begin
         failures++; $display("FAIL last_next_swap got=%b%b exp=1%b", frame_swap_o, rd_bank_o, ~bank0);
      end
   endtask

   task automatic test_underrun();
      int exp_u;
      rst = 1'b1; vga_vs_i = 1'b1; wr_valid_i = 1'b0; step();
      rst = 1'b0; step();
      for (int i = 0; i < 4; i++) begin
         vga_vs_i = 1'b1; step();
         vga_vs_i = 1'b0; step();
      end
`ifdef VGA_FB_UNDERRUN_CNT_EN
      exp_u = 3;
`else
      exp_u = 0;
`endif
      checks++; if (underrun_cnt_o !== 16'(exp_u)) begin failures++; $display("FAIL underrun got=%0d exp=%0d", underrun_cnt_o, exp_u); end
      checks++; if (dut_vec !== exp_vec()) begin failures++; $display("FAIL underrun_cyc got=%h exp=%h", dut_vec, exp_vec()); end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      vga_vs_i = 1'b0; wr_valid_i = 1'b1;
      while (m_waddr != 30 && n < 1000) begin
         wr_data_i = 8'($urandom_range(1, 255));
         step(); n++;
      end
      checks++; if (wr_en_o !== 1'b1) begin failures++; $display("FAIL mid_setup got=%b exp=1", wr_en_o); end
      rst = 1'b1; #1;
      reset_model();
      checks++; if ({wr_ready_o, wr_en_o, wr_addr_o, wr_data_o, frame_swap_o, rd_bank_o, rd_addr_o, underrun_cnt_o} !== 36'h0) begin
         failures++; $display("FAIL async_reset got=%b %b %0d %h %b %b %0d %0d exp=all zero", wr_ready_o, wr_en_o, wr_addr_o, wr_data_o, frame_swap_o, rd_bank_o, rd_addr_o, underrun_cnt_o);
      end
      vga_vs_i = 1'b1; step(); step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if ({wr_ready_o, wr_en_o} !== 2'b00) begin failures++; $display("FAIL mid_wait got=%b%b exp=00", wr_ready_o, wr_en_o); end
      end
      vga_vs_i = 1'b0; step();
      checks++; if (wr_ready_o !== 1'b1) begin failures++; $display("FAIL mid_resume got=%b exp=1", wr_ready_o); end
      wr_valid_i = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 4) vga_vs_i = ~vga_vs_i;
         wr_valid_i = ($urandom_range(0, 4) != 0);
         wr_data_i = 8'($urandom_range(0, 255));
         bram_en_i = $urandom_range(0, 1);
         step();
         checks++; if (dut_vec !== exp_vec()) begin failures++; $display("FAIL random_cyc t=%0t got=%h exp=%h", $time, dut_vec, exp_vec()); end
      end
   endtask

   initial begin
      reset_model();
      test_reset();
      test_first_vs();
      test_fill_and_swap();
      test_rd_saturate();
      test_last_with_vs();
      test_underrun();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
